// File: rtl/clk_div_sched_pkg.sv
// Shared types and helpers for the clock-divider scheduler.
// Provides counter/tap widths, the config FSM state type, the latched
// config request payload and the tap-to-mask helper.
package clk_div_sched_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TAP_W = 4;
    localparam int unsigned CH_W  = 3;

    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_e;

    // Config request held while waiting for the target's period boundary
    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [TAP_W-1:0] tap;
        logic             en;
    } cfg_req_t;

    // All-ones mask covering counter bits [tap:0]
    function automatic logic [CNT_W-1:0] tap_mask(input logic [TAP_W-1:0] tap);
        return CNT_ONES >> (CNT_W - 1 - 32'(tap));
    endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Configuration handshake bundle for clk_div_scheduler.
//   cfg_valid/cfg_ready : request handshake
//   cfg_ch/tap/en       : target channel, tap k (ratio 2^(k+1)), enable
//   cfg_err             : one-cycle pulse for an out-of-range channel
// master = requester, slave = scheduler.
interface clk_div_sched_if;
    import clk_div_sched_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [TAP_W-1:0] cfg_tap;
    logic             cfg_en;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_tap, cfg_en,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_tap, cfg_en,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clk_div_sched_chan.sv
// One consumer channel of the divider scheduler.
// Holds tap/en, detects its period boundary on the shared counter and
// registers the tick pulse and (optionally) the square wave.
// Build option: CLK_DIV_SCHED_SQUARE_EN builds the sq register; otherwise
// sq is tied low.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   run                 : counter running
//   cnt                 : shared free-running counter
//   load, load_tap/en   : strobe from the top FSM loading a new config
//   load_ok_c           : comb, a load now would not cut a period short
//   tick, sq            : registered outputs
module clk_div_sched_chan
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned DEFAULT_TAP = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic             load,
    input  logic [TAP_W-1:0] load_tap,
    input  logic             load_en,
    output logic             load_ok_c,
    output logic             tick,
    output logic             sq
);

    logic [TAP_W-1:0] tap_q;
    logic             en_q;
    logic [CNT_W-1:0] mask_c;
    logic             bnd_c;

    assign mask_c = tap_mask(tap_q);
    assign bnd_c  = run && ((cnt & mask_c) == mask_c);

    // Safe to switch ratio at the boundary, or whenever nothing is ticking
    assign load_ok_c = bnd_c || !en_q || !run;

    // Channel configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= TAP_W'(DEFAULT_TAP);
            en_q  <= 1'b1;
        end else if (load) begin
            tap_q <= load_tap;
            en_q  <= load_en;
        end
    end

    // Tick pulse, one cycle after the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= bnd_c && en_q;
        end
    end

`ifdef CLK_DIV_SCHED_SQUARE_EN
    // Square wave follows the tap bit of the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq <= 1'b0;
        end else begin
            sq <= cnt[tap_q] && en_q;
        end
    end
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/clk_div_scheduler.sv
// Synchronous clock-divider scheduler: one shared 16-bit counter serving
// N_CH channels, each with a tick enable and square wave at clk/2^(tap+1).
// Taps are reprogrammed through a valid/ready handshake and only take
// effect at the target channel's period boundary.
// Build option: CLK_DIV_SCHED_SQUARE_EN (see clk_div_sched_chan).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   run        : 1 = counter advances, 0 = counter held at 0
//   cfg        : config handshake (slave side of clk_div_sched_if)
//   tick       : per-channel one-cycle enable pulse
//   sq         : per-channel 50% square wave
module clk_div_scheduler
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEFAULT_TAP = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    clk_div_sched_if.slave  cfg,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sq
);

    cfg_state_e       state_q;
    cfg_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    cfg_req_t         pend_q;
    logic             bad_ch_c;
    logic             accept_c;
    logic             err_d;
    logic             pend_c;
    logic [N_CH-1:0]  load_ok_c;
    logic [N_CH-1:0]  load_c;

    assign bad_ch_c = (32'(cfg.cfg_ch) >= N_CH);

    // Shared free-running counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg.cfg_valid && !bad_ch_c) state_d = PEND;
            PEND:    if (|load_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        accept_c = 1'b0;
        err_d    = 1'b0;
        pend_c   = 1'b0;
        case (state_q)
            IDLE: begin
                accept_c = cfg.cfg_valid && !bad_ch_c;
                err_d    = cfg.cfg_valid && bad_ch_c;
            end
            PEND:    pend_c = 1'b1;
            default: ;
        endcase
    end

    // Latched request and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= '0;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                pend_q <= '{ch: cfg.cfg_ch, tap: cfg.cfg_tap, en: cfg.cfg_en};
            end
            cfg.cfg_ready <= (state_d == IDLE);
            cfg.cfg_err   <= err_d;
        end
    end

    // Channels; only the pending target may take the load strobe
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign load_c[i] = pend_c && (pend_q.ch == CH_W'(i)) && load_ok_c[i];

        clk_div_sched_chan #(
            .DEFAULT_TAP (DEFAULT_TAP)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (run),
            .cnt       (cnt_q),
            .load      (load_c[i]),
            .load_tap  (pend_q.tap),
            .load_en   (pend_q.en),
            .load_ok_c (load_ok_c[i]),
            .tick      (tick[i]),
            .sq        (sq[i])
        );
    end

endmodule
